qpp_interleaver: RTL and testbench

//  Buffers one K-bit code block of systematic bits ck and replays it in LTE QPP order
//  c'(i) = c(pi(i)), with pi(i) = (f1*i + f2*i^2) mod K.

---
 rtl/turbo_pkg.sv | 18 +
 rtl/interleaver_ram.sv | 19 +
 rtl/qpp_interleaver.sv | 149 ++++++++++++++
 tb/tb_qpp_interleaver.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/turbo_pkg.sv
// Shared constants, FSM encoding and the modular-add helper for the QPP interleaver.
package turbo_pkg;
  localparam int KMAX = 6144;
  localparam int AW   = 13;
  localparam int KMIN = 40;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  // (a + b) mod k for a, b < k: one add and a conditional subtract at AW+1 bits.
  function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a,
                                            input logic [AW-1:0] b,
                                            input logic [AW-1:0] k);
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, k}) s = s - {1'b0, k};
    return s[AW-1:0];
  endfunction
endpackage

// File: rtl/interleaver_ram.sv
// KMAX x 1 simple dual-port block store; registered read with one cycle of latency.
module interleaver_ram
  import turbo_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic          wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic          rdata
);
  logic mem [KMAX];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/qpp_interleaver.sv
// Loads one K-bit block in natural order and replays it in LTE QPP order c'(i) = c(pi(i)).
// Handshake: a bit moves on in_valid&&in_ready (input) or out_valid&&out_ready (output) at the rising edge.
module qpp_interleaver
  import turbo_pkg::*;
(
  input  logic          clk,
  input  logic          aclr,
  input  logic [31:0]   K,
  input  logic [AW-1:0] f1,
  input  logic [AW-1:0] f2,
  input  logic          start,
  input  logic          in_bit,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out_bit,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic          err,
  output state_t        dbg_state
);
  state_t        state;
  logic [AW-1:0] k_r, k_m1, wcnt, rcnt, pi, g, step2;
  logic          rd_pending, rd_last, rd_q;
  logic          sk_valid, sk_bit, sk_last;
  logic          bad_cfg, xfer, issue;
  logic [31:0]   kdec;
  logic [1:0]    occ;

  assign dbg_state = state;

  always_comb begin
    kdec    = K - 32'd1;
    bad_cfg = (K < 32'(KMIN)) || (K > 32'(KMAX)) || (K[2:0] != 3'd0) ||
              ({{(32-AW){1'b0}}, f1} >= K) || ({{(32-AW){1'b0}}, f2} >= K);
    xfer    = out_valid && out_ready;
    // Items held or in flight: output register, skid entry and the pending RAM read.
    occ     = {1'b0, out_valid} + {1'b0, sk_valid} + {1'b0, rd_pending};
    issue   = (state == DRAIN) && (rcnt != k_r) && ((occ - {1'b0, xfer}) < 2'd2);
  end

  interleaver_ram u_ram (
    .clk   (clk),
    .we    ((state == LOAD) && in_valid && in_ready),
    .waddr (wcnt),
    .wdata (in_bit),
    .re    (issue),
    .raddr (pi),
    .rdata (rd_q)
  );

  always_ff @(posedge clk) begin
    if (aclr) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_bit    <= 1'b0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      k_r        <= '0;
      k_m1       <= '0;
      wcnt       <= '0;
      rcnt       <= '0;
      pi         <= '0;
      g          <= '0;
      step2      <= '0;
      rd_pending <= 1'b0;
      rd_last    <= 1'b0;
      sk_valid   <= 1'b0;
      sk_bit     <= 1'b0;
      sk_last    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (bad_cfg) begin
              err <= 1'b1;
            end else begin
              k_r      <= K[AW-1:0];
              k_m1     <= kdec[AW-1:0];
              g        <= mod_add(f1, f2, K[AW-1:0]);
              step2    <= mod_add(f2, f2, K[AW-1:0]);
              wcnt     <= '0;
              rcnt     <= '0;
              pi       <= '0;
              in_ready <= 1'b1;
              busy     <= 1'b1;
              state    <= LOAD;
            end
          end
        end
        LOAD: begin
          if (in_valid) begin
            wcnt <= wcnt + AW'(1);
            if (wcnt == k_m1) begin
              in_ready <= 1'b0;
              state    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (issue) begin
            pi   <= mod_add(pi, g, k_r);
            g    <= mod_add(g, step2, k_r);
            rcnt <= rcnt + AW'(1);
          end
          rd_pending <= issue;
          rd_last    <= issue && (rcnt == k_m1);
          if (!out_valid || out_ready) begin
            // Output register is free: refill from the skid first to keep order.
            if (sk_valid) begin
              out_valid <= 1'b1;
              out_bit   <= sk_bit;
              out_last  <= sk_last;
              sk_valid  <= rd_pending;
              sk_bit    <= rd_q;
              sk_last   <= rd_last;
            end else if (rd_pending) begin
              out_valid <= 1'b1;
              out_bit   <= rd_q;
              out_last  <= rd_last;
            end else begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end
          end else if (rd_pending) begin
            sk_valid <= 1'b1;
            sk_bit   <= rd_q;
            sk_last  <= rd_last;
          end
          if (xfer && out_last) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_qpp_interleaver.sv
// Directed bench for qpp_interleaver: hand-built one-hot blocks, a formula-based QPP model and error cases.
module tb_qpp_interleaver;
  import turbo_pkg::*;

  logic          clk = 1'b0;
  logic          aclr;
  logic [31:0]   K;
  logic [AW-1:0] f1, f2;
  logic          start, in_bit, in_valid, in_ready;
  logic          out_bit, out_valid, out_ready, out_last;
  logic          busy, done, err;
  state_t        dbg_state;

  int   total = 0;
  int   bad   = 0;
  logic data_mem [KMAX];
  logic [0:0] exp_q[$];

  qpp_interleaver dut (
    .clk       (clk),
    .aclr      (aclr),
    .K         (K),
    .f1        (f1),
    .f2        (f2),
    .start     (start),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    check({tag, "_in_ready"}, 32'(in_ready), 0);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_out_last"}, 32'(out_last), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic start_block(input int k, input int a, input int b);
    K     = 32'(k);
    f1    = AW'(a);
    f2    = AW'(b);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_bits(input int n, input bit gaps);
    int j = 0;
    while (j < n) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_bit   = data_mem[j];
        check("load_ready", 32'(in_ready), 1);
        j++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Sits at a negedge and handles one output cycle per negedge until K bits are seen.
  task automatic drain(input int k, input bit rand_rdy, input int poke_cyc);
    int   cyc = 0, got = 0, first_v = -1, first_x = 0, last_x = 0;
    bit   hold = 1'b0;
    logic hb = 1'b0, hl = 1'b0;
    logic [0:0] e;
    while (got < k && cyc < 4 * k + 50) begin
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke_cyc >= 0 && cyc == poke_cyc) begin
        K     = 32'd39;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (poke_cyc >= 0 && cyc == poke_cyc + 1) begin
        check("poke_no_err", 32'(err), 0);
        check("poke_state", 32'(dbg_state), 32'(DRAIN));
      end
      if (hold) begin
        check("hold_valid", 32'(out_valid), 1);
        check("hold_bit", 32'(out_bit), 32'(hb));
        check("hold_last", 32'(out_last), 32'(hl));
      end
      if (out_valid && first_v < 0) first_v = cyc;
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        check($sformatf("bit_i%0d", got), 32'(out_bit), 32'(e));
        check($sformatf("last_i%0d", got), 32'(out_last), 32'(got == k - 1));
        if (got == 0) first_x = cyc;
        last_x = cyc;
        got++;
      end
      hold = out_valid && !out_ready;
      hb   = out_bit;
      hl   = out_last;
      @(negedge clk);
      cyc++;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    check("drain_count", 32'(got), 32'(k));
    check("first_valid_cycle", 32'(first_v), 2);
    if (!rand_rdy) check("drain_span", 32'(last_x - first_x), 32'(k - 1));
    check("done_pulse", 32'(done), 1);
    check("after_valid", 32'(out_valid), 0);
    check("after_state", 32'(dbg_state), 32'(IDLE));
    check("after_busy", 32'(busy), 0);
  endtask

  task automatic run_block(input int k, input int a, input int b, input bit gaps,
                           input bit rand_rdy, input int poke_cyc);
    start_block(k, a, b);
    check("accept_state", 32'(dbg_state), 32'(LOAD));
    check("accept_ready", 32'(in_ready), 1);
    check("accept_busy", 32'(busy), 1);
    check("accept_err", 32'(err), 0);
    load_bits(k, gaps);
    check("drain_state", 32'(dbg_state), 32'(DRAIN));
    check("drain_in_ready", 32'(in_ready), 0);
    drain(k, rand_rdy, poke_cyc);
  endtask

  task automatic onehot(input int k, input int j, input int hot);
    for (int n = 0; n < k; n++) data_mem[n] = (n == j);
    exp_q.delete();
    for (int i = 0; i < k; i++) exp_q.push_back(1'(i == hot));
  endtask

  task automatic model_fill(input int k, input int a, input int b);
    longint p;
    for (int n = 0; n < k; n++) data_mem[n] = 1'($urandom_range(0, 1));
    exp_q.delete();
    for (int i = 0; i < k; i++) begin
      p = (longint'(a) * i + longint'(b) * i * i) % k;
      exp_q.push_back(data_mem[int'(p)]);
    end
  endtask

  task automatic reject(input int k, input int a, input int b);
    start_block(k, a, b);
    check($sformatf("err_k%0d_f1_%0d_f2_%0d", k, a, b), 32'(err), 1);
    check_idle_outputs("reject");
    @(negedge clk);
    check("err_single", 32'(err), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    aclr = 1'b1; K = 32'd0; f1 = '0; f2 = '0; start = 1'b0;
    in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_done", 32'(done), 0);
    check("reset_err", 32'(err), 0);
    check("reset_out_bit", 32'(out_bit), 0);
    aclr = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset");

    // One-hot blocks for K=40, f1=3, f2=10: pi = 0,13,6,19,...
    onehot(40, 13, 1);  run_block(40, 3, 10, 1'b0, 1'b0, -1);
    onehot(40, 6, 2);   run_block(40, 3, 10, 1'b0, 1'b0, -1);
    onehot(40, 19, 3);  run_block(40, 3, 10, 1'b1, 1'b0, -1);
    @(negedge clk);
    check("done_single", 32'(done), 0);

    model_fill(6144, 263, 480);
    run_block(6144, 263, 480, 1'b0, 1'b0, -1);

    onehot(40, 13, 1);  run_block(40, 3, 10, 1'b0, 1'b1, -1);
    model_fill(48, 7, 12);
    run_block(48, 7, 12, 1'b1, 1'b1, -1);

    @(negedge clk);
    reject(39, 3, 10);
    reject(44, 3, 10);
    reject(40, 40, 10);
    reject(40, 3, 40);
    reject(6152, 263, 480);

    // Abort part-way through a load, then run a fresh block.
    onehot(40, 13, 1);
    start_block(40, 3, 10);
    load_bits(20, 1'b0);
    aclr = 1'b1;
    @(negedge clk);
    check_idle_outputs("abort");
    aclr = 1'b0;
    @(negedge clk);
    onehot(40, 19, 3);  run_block(40, 3, 10, 1'b0, 1'b0, -1);

    // A start during DRAIN is ignored; the next start lands in the done cycle.
    onehot(40, 6, 2);   run_block(40, 3, 10, 1'b0, 1'b0, 10);
    onehot(40, 13, 1);  run_block(40, 3, 10, 1'b0, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
